// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the six-stage pipeline hazard controller:
// FSM states, forward-select codes and the scoreboard entry.
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW_D = 3;
    localparam int CNT_W_D  = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_EX = 2'd1;
    localparam logic [1:0] FWD_MA = 2'd2;
    localparam logic [1:0] FWD_WB = 2'd3;

    typedef struct packed {
        logic                valid;
        logic [REG_AW_D-1:0] rd;
        logic                is_load;
    } sb_entry_t;

    function automatic logic sb_hit(
        input logic                used,
        input logic [REG_AW_D-1:0] rs,
        input sb_entry_t           e
    );
        return used && e.valid && (e.rd == rs);
    endfunction

    // Youngest producer wins: EX, then MA, then WB.
    function automatic logic [1:0] fwd_pick(
        input logic                rr_valid,
        input logic                used,
        input logic [REG_AW_D-1:0] rs,
        input sb_entry_t           ex,
        input sb_entry_t           ma,
        input sb_entry_t           wb
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (!rr_valid)
            sel = FWD_RF;
        else if (sb_hit(used, rs, ex))
            sel = FWD_EX;
        else if (sb_hit(used, rs, ma))
            sel = FWD_MA;
        else if (sb_hit(used, rs, wb))
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-facing bundle of the hazard controller: RR source info,
// EX status in, load enables / bubble / flush / forwards / counters out.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic              rr_valid;
    logic [REG_AW-1:0] rr_rs1;
    logic [REG_AW-1:0] rr_rs2;
    logic              rr_rs1_used;
    logic              rr_rs2_used;
    logic [REG_AW-1:0] rr_rd;
    logic              rr_wr;
    logic              rr_is_load;
    logic              ex_redirect;
    logic              ex_busy;

    logic              pc_ld;
    logic              if_id_ld;
    logic              id_rr_ld;
    logic              rr_ex_bubble;
    logic              flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output rr_valid, rr_rs1, rr_rs2, rr_rs1_used, rr_rs2_used,
        output rr_rd, rr_wr, rr_is_load, ex_redirect, ex_busy,
        input  pc_ld, if_id_ld, id_rr_ld, rr_ex_bubble, flush,
        input  fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  rr_valid, rr_rs1, rr_rs2, rr_rs1_used, rr_rs2_used,
        input  rr_rd, rr_wr, rr_is_load, ex_redirect, ex_busy,
        output pc_ld, if_id_ld, id_rr_ld, rr_ex_bubble, flush,
        output fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (clear)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Six-stage pipeline hazard controller: EX/MA/WB destination scoreboard,
// load-use stall, redirect flush, multi-cycle hold and operand forwarding.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_D,
    parameter int CNT_W  = CNT_W_D
) (
    input logic               clk,
    input logic               resetn,
    pipe_hazard_ctrl_if.slave bus
);
    state_t    state;
    state_t    state_nx;
    sb_entry_t sb_ex;
    sb_entry_t sb_ma;
    sb_entry_t sb_wb;
    sb_entry_t sb_new;

    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;

    logic       load_use;
    logic       ld;
    logic       bubble;
    logic       fl;
    logic       freeze;
    logic       adv;
    logic       stall_inc;
    logic       flush_inc;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    assign rs1 = bus.rr_rs1;
    assign rs2 = bus.rr_rs2;
    assign rd  = bus.rr_rd;

    // RR holds a squashed instruction in FLUSH, so it cannot raise load-use.
    assign load_use = bus.rr_valid && (state != FLUSH) && sb_ex.is_load &&
                      (sb_hit(bus.rr_rs1_used, rs1, sb_ex) ||
                       sb_hit(bus.rr_rs2_used, rs2, sb_ex));

    assign fwd_a = fwd_pick(bus.rr_valid, bus.rr_rs1_used, rs1,
                            sb_ex, sb_ma, sb_wb);
    assign fwd_b = fwd_pick(bus.rr_valid, bus.rr_rs2_used, rs2,
                            sb_ex, sb_ma, sb_wb);

    always_comb begin
        state_nx  = RUN;
        ld        = 1'b1;
        bubble    = 1'b0;
        fl        = 1'b0;
        freeze    = 1'b0;
        adv       = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (!resetn) begin
            ld     = 1'b0;
            bubble = 1'b1;
            fl     = 1'b1;
        end else if (bus.ex_redirect) begin
            state_nx  = FLUSH;
            bubble    = 1'b1;
            fl        = 1'b1;
            flush_inc = 1'b1;
        end else if (bus.ex_busy) begin
            state_nx  = HOLD;
            ld        = 1'b0;
            freeze    = 1'b1;
            stall_inc = 1'b1;
        end else if (load_use) begin
            state_nx  = STALL;
            ld        = 1'b0;
            bubble    = 1'b1;
            stall_inc = 1'b1;
        end else begin
            adv = bus.rr_valid && bus.rr_wr;
        end
    end

    always_comb begin
        sb_new = '0;
        if (adv) begin
            sb_new.valid   = 1'b1;
            sb_new.rd      = rd;
            sb_new.is_load = bus.rr_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= RUN;
            sb_ex <= '0;
            sb_ma <= '0;
            sb_wb <= '0;
        end else begin
            state <= state_nx;
            if (!freeze) begin
                sb_wb <= sb_ma;
                sb_ma <= sb_ex;
                sb_ex <= sb_new;
            end
        end
    end

    assign bus.pc_ld        = ld;
    assign bus.if_id_ld     = ld;
    assign bus.id_rr_ld     = ld;
    assign bus.rr_ex_bubble = bubble;
    assign bus.flush        = fl;
    assign bus.fwd_a_sel    = resetn ? fwd_a : FWD_RF;
    assign bus.fwd_b_sel    = resetn ? fwd_b : FWD_RF;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (!resetn),
        .inc   (stall_inc),
        .cnt   (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (!resetn),
        .inc   (flush_inc),
        .cnt   (bus.flush_cnt)
    );
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the six-stage IITB RISC pipeline: IF, ID, RR, EX, MA, WB. It tracks in-flight destination registers in a three-entry scoreboard (EX, MA, WB). Each cycle it compares them against the source registers of the instruction in RR and drives the pipeline-register load enables, RR→EX bubble insertion, the ID/RR flush, and the EX operand forwarding selects. It also keeps saturating stall and flush counters for performance bring-up.

## Interface
- REG_AW, 3, register address width (R0–R7)
- CNT_W, 16, width of performance counters
- clk  in  1  pipeline clock, rising edge
- resetn  in  1  reset, synchronous, active-low
- rr_valid  in  1  RR stage holds a real instruction
- rr_rs1, rr_rs2  in  REG_AW  source register addresses in RR
- rr_rs1_used, rr_rs2_used  in  1  source actually read
- rr_rd  in  REG_AW  destination register of RR instruction
- rr_wr  in  1  RR instruction writes rr_rd
- rr_is_load  in  1  RR instruction is LW/LM (data valid only after MA)
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- ex_busy  in  1  EX is executing a multi-cycle op (LM/SM); freeze front end
- pc_ld, if_id_ld, id_rr_ld  out  1  load enables for PC, IF/ID, ID/RR
- rr_ex_bubble  out  1  load a NOP (valid=0) into RR/EX instead of RR data
- flush  out  1  squash IF/ID and ID/RR contents
- fwd_a_sel, fwd_b_sel  out  2  0=register file, 1=EX result, 2=MA result, 3=WB result
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Scoreboard entry = {valid, rd, is_load}. Advance each cycle unless ex_busy: WB←MA, MA←EX, EX←(RR entry if RR advances, else invalid).
- Match(s, e): rs_used && e.valid && e.rd == rs. Forward priority EX > MA > WB. The WB match is needed because the register file is written on the same edge.
- Load-use: RR source matches EX entry with is_load=1 → 1-cycle stall. Hold PC, IF/ID, ID/RR; rr_ex_bubble=1. Next cycle the match falls to MA, so fwd=2 and the pipe proceeds.
- FSM states: RUN, STALL, HOLD, FLUSH.
  - RUN → STALL on load-use.
  - any → HOLD while ex_busy.
  - any → FLUSH on ex_redirect.
  - STALL/FLUSH → RUN after one cycle.
  - HOLD → RUN when ex_busy drops.
- Priority: resetn low > ex_redirect > ex_busy > load-use.
- FLUSH: flush=1 and rr_ex_bubble=1 in the redirect cycle. All loads=1, so the PC takes the target. The EX scoreboard entry for the next cycle is invalid. The FLUSH state suppresses load-use detection for one cycle because RR holds a squashed instruction.
- HOLD: all loads=0. rr_ex_bubble=0. The scoreboard is frozen. fwd selects are still computed.
- fwd selects are 0 when rr_valid=0.
- stall_cnt increments per STALL or HOLD cycle. flush_cnt increments per ex_redirect cycle. Both saturate at all-ones.

## Timing
- Control outputs are combinational from inputs and registered state, so they are valid in the same cycle. The scoreboard, FSM, and counters are registered.
- Reset (resetn=0 at an edge): state=RUN, scoreboard invalid, counters=0. While resetn=0, pc_ld/if_id_ld/id_rr_ld=0, rr_ex_bubble=1, flush=1, fwd=0.
- Reset mid-stall or mid-HOLD aborts it. There is no residual stall after release.
- Load-use latency is exactly 1 bubble. A back-to-back dependent non-load needs 0 bubbles.
- ex_redirect during STALL: the flush wins, the stall is dropped, and the state goes to FLUSH.
- ex_redirect during HOLD: ignored. EX cannot redirect while busy; the bench asserts they are never both high.
- rs1 and rs2 both hazarded: one stall only, with independent fwd selects.
- Counter at all-ones stays all-ones.

## Structure
- A shared package holds: the FSM state enum, the forward-select constants (FWD_RF, FWD_EX, FWD_MA, FWD_WB), and the scoreboard entry struct.
- One sub-module: sat_counter (parameter CNT_W, inputs inc and clear), instantiated twice.
- The top level contains the scoreboard, the comparators, and the FSM.

## Test plan
- ADD R1 in EX, RR reads R1 → fwd_a_sel=1, no bubble, stall_cnt stays 0.
- LW R2 in EX, RR reads R2 as rs2 → one cycle of pc_ld=0 and rr_ex_bubble=1. Next cycle fwd_b_sel=2, stall_cnt=1.
- R3 written by EX, MA, and WB entries, RR reads R3 → fwd=1, which shows the EX priority.
- ex_redirect on the same cycle as a load-use → flush=1, no stall, flush_cnt=1, state FLUSH then RUN.
- ex_busy high for 4 cycles → all loads 0 for 4 cycles, scoreboard unchanged, stall_cnt=4.
- resetn low during HOLD with counters preloaded to all-ones → counters 0, state RUN, outputs at their reset values.
